// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage computing the next PC, issuing one imem read per PC and
// presenting the returned word to decode over valid/ready, with redirect flush.
module instr_fetch #(
  parameter int                 BITSIZE   = 32,
  parameter logic [BITSIZE-1:0] RESET_PC  = '0,
  parameter logic [BITSIZE-1:0] NOP_INSTR = 'h13
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [BITSIZE-1:0] pc_in,
  output logic [BITSIZE-1:0] pc_next,
  input  logic               redirect_valid,
  input  logic [BITSIZE-1:0] redirect_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [BITSIZE-1:0] imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [BITSIZE-1:0] imem_resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] out_instr,
  output logic [BITSIZE-1:0] out_pc,
  output logic               out_fault
);
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  state_t state, state_nx;
  logic [BITSIZE-1:0] req_pc;
  logic slot_free, req_valid, fire, load, fault_load;
  assign slot_free      = !out_valid || out_ready;
  assign imem_req_valid = req_valid && !reset;
  assign imem_req_addr  = pc_in;
  assign fire           = imem_req_valid && imem_req_ready;
  assign pc_next        = reset ? RESET_PC : redirect_valid ? redirect_target :
                          fire ? pc_in + BITSIZE'(4) : pc_in;
  always_comb begin
    state_nx   = state;
    req_valid  = 1'b0;
    load       = 1'b0;
    fault_load = 1'b0;
    case (state)
      REQ: if (!redirect_valid) begin
        fault_load = (|pc_in[1:0]) && slot_free;
        req_valid  = !(|pc_in[1:0]) && slot_free;
        state_nx   = (req_valid && imem_req_ready) ? WAIT : REQ;
      end
      WAIT: begin
        load     = imem_resp_valid && !redirect_valid;
        state_nx = imem_resp_valid ? REQ : redirect_valid ? DROP : WAIT;
      end
      DROP:    state_nx = imem_resp_valid ? REQ : DROP;
      default: state_nx = REQ;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= REQ;
      out_valid <= 1'b0;
      out_fault <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      req_pc    <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= !redirect_valid && (load || fault_load || (out_valid && !out_ready));
      if (fire) req_pc <= pc_in;
      if (load || fault_load) begin
        out_instr <= fault_load ? NOP_INSTR : imem_resp_data;
        out_pc    <= fault_load ? pc_in : req_pc;
        out_fault <= fault_load;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a PC register and latency-programmable memory.
module tb_instr_fetch;
  logic        clock = 0, reset = 1;
  logic [31:0] pc, pc_next, redirect_target = 0, req_addr, resp_data = 0, out_instr, out_pc;
  logic        redirect_valid = 0, req_valid, req_ready = 1, resp_valid = 0;
  logic        out_valid, out_ready = 1, out_fault;
  int          n_chk = 0, n_fail = 0, lat = 1, cnt = 0;
  logic        pend = 0;
  logic [31:0] paddr = 0;
  instr_fetch dut (
    .clock(clock), .reset(reset), .pc_in(pc), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );
  always #5 clock = ~clock;
  always @(posedge clock or posedge reset) pc <= reset ? 32'h0 : pc_next;
  // memory: response valid for one cycle, lat cycles after the accepting edge
  always @(posedge clock) begin
    resp_valid <= 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        resp_valid <= 1'b1;
        resp_data  <= paddr ^ 32'hDEAD0000;
        pend       <= 1'b0;
      end else cnt <= cnt - 1;
    end
    if (req_valid && req_ready) begin
      if (lat == 1) begin
        resp_valid <= 1'b1;
        resp_data  <= req_addr ^ 32'hDEAD0000;
      end else begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= req_addr;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic nedge();
    @(negedge clock);
  endtask
  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1; redirect_target = t;
    #1;
    check("redir_pcnext", pc_next, t);
    check("redir_reqv", {31'b0, req_valid}, 0);
    @(posedge clock); #1;
    redirect_valid = 0;
  endtask
  initial begin
    nedge();
    check("rst_outv", {31'b0, out_valid}, 0);
    check("rst_reqv", {31'b0, req_valid}, 0);
    check("rst_pcnext", pc_next, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    #2 reset = 0;
    // 1: streaming fetch, one instruction every two cycles
    nedge();
    check("t1_wait_reqv", {31'b0, req_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      nedge();
      check("t1_outv", {31'b0, out_valid}, 1);
      check("t1_outpc", out_pc, 4 * i);
      check("t1_instr", out_instr, (4 * i) ^ 32'hDEAD0000);
      check("t1_reqaddr", req_addr, 4 * i + 4);
      if (i < 2) begin
        nedge();
        check("t1_gap", {31'b0, out_valid}, 0);
      end
    end
    // 2: decode back-pressure
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      nedge();
      check("t2_outv", {31'b0, out_valid}, 1);
      check("t2_outpc", out_pc, 8);
      check("t2_instr", out_instr, 32'hDEAD0008);
      check("t2_reqv", {31'b0, req_valid}, 0);
      check("t2_pcnext", pc_next, 12);
    end
    out_ready = 1;
    nedge();
    check("t2_gap", {31'b0, out_valid}, 0);
    nedge();
    check("t2_outpc", out_pc, 12);
    check("t2_instr", out_instr, 32'hDEAD000C);
    // 3: redirect during WAIT drops the late response
    lat = 2;
    nedge();
    check("t3_wait", {31'b0, req_valid}, 0);
    redirect(32'h100);
    nedge();
    check("t3_drop_outv", {31'b0, out_valid}, 0);
    check("t3_drop_resp", {31'b0, resp_valid}, 1);
    check("t3_drop_reqv", {31'b0, req_valid}, 0);
    nedge();
    check("t3_reqv", {31'b0, req_valid}, 1);
    check("t3_reqaddr", req_addr, 32'h100);
    check("t3_outv", {31'b0, out_valid}, 0);
    nedge(); check("t3_stale1", {31'b0, out_valid}, 0);
    nedge(); check("t3_stale2", {31'b0, out_valid}, 0);
    nedge();
    check("t3_outv", {31'b0, out_valid}, 1);
    check("t3_outpc", out_pc, 32'h100);
    check("t3_instr", out_instr, 32'hDEAD0100);
    // 4: memory back-pressure
    req_ready = 0; lat = 1;
    for (int i = 0; i < 3; i++) begin
      nedge();
      check("t4_reqv", {31'b0, req_valid}, 1);
      check("t4_addr", req_addr, 32'h104);
      check("t4_pcnext", pc_next, 32'h104);
    end
    req_ready = 1;
    nedge(); nedge();
    check("t4_outpc", out_pc, 32'h104);
    check("t4_instr", out_instr, 32'hDEAD0104);
    // 5: misaligned redirect target
    redirect(32'h102);
    nedge();
    check("t5_reqv0", {31'b0, req_valid}, 0);
    nedge();
    check("t5_outv", {31'b0, out_valid}, 1);
    check("t5_fault", {31'b0, out_fault}, 1);
    check("t5_instr", out_instr, 32'h13);
    check("t5_outpc", out_pc, 32'h102);
    nedge();
    check("t5_reqv1", {31'b0, req_valid}, 0);
    check("t5_pcnext", pc_next, 32'h102);
    redirect(32'h200);
    nedge();
    check("t5_new_reqv", {31'b0, req_valid}, 1);
    check("t5_new_addr", req_addr, 32'h200);
    check("t5_flush", {31'b0, out_valid}, 0);
    // 6: reset while waiting; the late response must be ignored
    lat = 2;
    nedge();
    check("t6_wait", {31'b0, req_valid}, 0);
    req_ready = 0; reset = 1;
    #1;
    check("t6_outpc", out_pc, 0);
    check("t6_instr", out_instr, 0);
    check("t6_fault", {31'b0, out_fault}, 0);
    check("t6_pcnext", pc_next, 0);
    check("t6_reqv", {31'b0, req_valid}, 0);
    #2 reset = 0;
    nedge();
    check("t6_oldresp", {31'b0, resp_valid}, 1);
    nedge();
    check("t6_ignored", {31'b0, out_valid}, 0);
    check("t6_reqaddr", req_addr, 0);
    req_ready = 1;
    nedge(); nedge(); nedge();
    check("t6_outv", {31'b0, out_valid}, 1);
    check("t6_outpc", out_pc, 0);
    check("t6_instr", out_instr, 32'hDEAD0000);
    // wrap at the top of the address space
    redirect(32'hFFFFFFFC);
    nedge();
    check("wrap_flush", {31'b0, out_valid}, 0);
    check("wrap_addr", req_addr, 32'hFFFFFFFC);
    check("wrap_pcnext", pc_next, 0);
    nedge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
